// File: rtl/led_game_pkg.sv
// Shared constants for the LED game input path: button count, button indices and
// debounce/auto-repeat defaults.
package led_game_pkg;

  localparam int unsigned NUM_BUTTONS_DEF     = 7;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 1000;
  localparam int unsigned REPEAT_DELAY_DEF    = 50000;
  localparam int unsigned REPEAT_PERIOD_DEF   = 10000;

  localparam int unsigned BTN_0 = 0;
  localparam int unsigned BTN_1 = 1;
  localparam int unsigned BTN_2 = 2;
  localparam int unsigned BTN_3 = 3;
  localparam int unsigned BTN_4 = 4;
  localparam int unsigned BTN_5 = 5;
  localparam int unsigned BTN_6 = 6;

  typedef enum logic [0:0] {
    RepDelay,
    RepPeriod
  } rep_phase_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-flop synchronizer, debounce counter, stable level and press pulse.
// Auto-repeat pulses are added when LED_BTN_REPEAT_EN is defined.
module debounce_channel
  import led_game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_i,
  output logic level_o,
  output logic pulse_o
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic            sync1_q, sync2_q;
  logic            stable_q, stable_d;
  logic            pulse_q, pulse_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            accept;
  logic            press_accept;
  logic            release_accept;

  assign accept         = (sync2_q != stable_q) && (cnt_q == CntLast);
  assign press_accept   = accept & sync2_q;
  assign release_accept = accept & ~sync2_q;

  always_comb begin
    cnt_d    = cnt_q;
    stable_d = stable_q;
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

`ifdef LED_BTN_REPEAT_EN
  localparam int unsigned RepW = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  localparam logic [RepW-1:0] DelayLast  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodLast = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] rep_cnt_q, rep_cnt_d;
  rep_phase_e      rep_phase_q, rep_phase_d;
  logic            rep_fire;

  // Counter restarts on every fresh press and is held clear while released or releasing.
  always_comb begin
    rep_cnt_d   = rep_cnt_q;
    rep_phase_d = rep_phase_q;
    rep_fire    = 1'b0;
    if (press_accept || !stable_q || release_accept) begin
      rep_cnt_d   = '0;
      rep_phase_d = RepDelay;
    end else if (rep_cnt_q == ((rep_phase_q == RepDelay) ? DelayLast : PeriodLast)) begin
      rep_fire    = 1'b1;
      rep_cnt_d   = '0;
      rep_phase_d = RepPeriod;
    end else begin
      rep_cnt_d = rep_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rep_cnt_q   <= '0;
      rep_phase_q <= RepDelay;
    end else begin
      rep_cnt_q   <= rep_cnt_d;
      rep_phase_q <= rep_phase_d;
    end
  end

  assign pulse_d = press_accept | rep_fire;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
  assign pulse_d = press_accept;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      pulse_q  <= 1'b0;
    end else begin
      sync1_q  <= raw_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      pulse_q  <= pulse_d;
    end
  end

  assign level_o = stable_q;
  assign pulse_o = pulse_q;

endmodule

// File: rtl/led_button_conditioner.sv
// Debounces the raw push-button lines into clean levels and single-cycle press events.
// Optional auto-repeat is enabled by defining LED_BTN_REPEAT_EN.
module led_button_conditioner
  import led_game_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS     = NUM_BUTTONS_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] raw_buttons,
  output logic [NUM_BUTTONS-1:0] buttons_level,
  output logic [NUM_BUTTONS-1:0] press_pulse,
  output logic                   any_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD)
    ) u_chan (
      .clock  (clock),
      .reset  (reset),
      .raw_i  (raw_buttons[i]),
      .level_o(buttons_level[i]),
      .pulse_o(press_pulse[i])
    );
  end

  assign any_press = |press_pulse;

endmodule

// File: tb/tb_led_button_conditioner.sv
// Directed self-checking bench for led_button_conditioner with DEBOUNCE_CYCLES=4.
module tb_led_button_conditioner;

  logic       clock;
  logic       reset;
  logic [6:0] raw_buttons;
  logic [6:0] buttons_level;
  logic [6:0] press_pulse;
  logic       any_press;

  int checks = 0;
  int errors = 0;

  led_button_conditioner #(
    .NUM_BUTTONS    (7),
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY   (8),
    .REPEAT_PERIOD  (3)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .raw_buttons  (raw_buttons),
    .buttons_level(buttons_level),
    .press_pulse  (press_pulse),
    .any_press    (any_press)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [6:0] lvl, input logic [6:0] pls);
    chk({tag, "_level"}, buttons_level, lvl);
    chk({tag, "_pulse"}, press_pulse, pls);
    chk({tag, "_any"}, {6'b0, any_press}, {6'b0, |pls});
  endtask

  // Drive raw level at edge 0 and check the press event lands after edge 5 only.
  task automatic press_and_check(input string tag, input logic [6:0] raw, input logic [6:0] prev);
    raw_buttons = raw;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk_all({tag, "_pre"}, prev, 7'h00);
    end
    tick();
    chk_all({tag, "_edge5"}, raw, raw & ~prev);
    tick();
    chk_all({tag, "_edge6"}, raw, 7'h00);
  endtask

  logic [6:0] exp_p;

  initial begin
    reset       = 1'b1;
    raw_buttons = 7'h7F;
    #1;
    chk_all("rst_async", 7'h00, 7'h00);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_all("rst_hold", 7'h00, 7'h00);
    end
    reset = 1'b0;
    press_and_check("rst_held", 7'h7F, 7'h00);
    tick();
    chk_all("rst_held_stay", 7'h7F, 7'h00);
    press_and_check("rst_rel", 7'h00, 7'h7F);

    press_and_check("clean", 7'b0000100, 7'h00);
    press_and_check("clean_rel", 7'h00, 7'b0000100);

    for (int r = 0; r < 2; r++) begin
      raw_buttons = 7'h01;
      for (int k = 0; k < 3; k++) begin
        tick();
        chk_all("bounce_hi", 7'h00, 7'h00);
      end
      raw_buttons = 7'h00;
      tick();
      chk_all("bounce_lo", 7'h00, 7'h00);
    end
    press_and_check("bounce_hold", 7'h01, 7'h00);
    press_and_check("bounce_rel", 7'h00, 7'h01);

    press_and_check("simul", 7'b0100010, 7'h00);
    press_and_check("simul_rel", 7'h00, 7'b0100010);

    raw_buttons = 7'b0001000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("mid_pre", 7'h00, 7'h00);
    end
    reset = 1'b1;
    #1;
    chk_all("mid_async", 7'h00, 7'h00);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk_all("mid_hold", 7'h00, 7'h00);
    end
    reset = 1'b0;
    press_and_check("mid_after", 7'b0001000, 7'h00);
    press_and_check("mid_rel", 7'h00, 7'b0001000);

    // Hold button 4; release is timed so the release edge (offset 23) lands on a repeat slot.
    raw_buttons = 7'b0010000;
    for (int e = 0; e <= 4; e++) begin
      tick();
      chk_all("rep_pre", 7'h00, 7'h00);
    end
    for (int o = 0; o <= 30; o++) begin
      if (o == 18) raw_buttons = 7'h00;
      tick();
      exp_p = 7'h00;
      if (o == 0) exp_p = 7'b0010000;
`ifdef LED_BTN_REPEAT_EN
      if (o >= 8 && o < 23 && ((o - 8) % 3) == 0) exp_p = 7'b0010000;
`endif
      chk_all($sformatf("rep_o%0d", o), (o < 23) ? 7'b0010000 : 7'h00, exp_p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("FAIL timeout observed running expected finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
